// File: rtl/axi_slave_responder_if.sv
// AXI4 AW/W/B/AR/R channel bundle between the protocol master and the responder.
interface axi_slave_responder_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
);
    localparam int unsigned SW = DW / 8;

    // Write address channel
    logic [AW-1:0] axi_awaddr;
    logic [7:0]    axi_awlen;
    logic [2:0]    axi_awsize;
    logic [1:0]    axi_awburst;
    logic          axi_awvalid;
    logic          axi_awready;
    // Write data channel
    logic [DW-1:0] axi_wdata;
    logic [SW-1:0] axi_wstrb;
    logic          axi_wlast;
    logic          axi_wvalid;
    logic          axi_wready;
    // Write response channel
    logic [1:0]    axi_bresp;
    logic          axi_bvalid;
    logic          axi_bready;
    // Read address channel
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic          axi_arvalid;
    logic          axi_arready;
    // Read data channel
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;

    modport slave (
        input  axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready
    );

    modport master (
        output axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready
    );
endinterface

// File: rtl/axi_slave_responder.sv
// AXI4 responder: independent write and read burst FSMs sharing one word memory.
module axi_slave_responder #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 64,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  axi_aclk,
    input  logic                  rst,
    axi_slave_responder_if.slave  axi
);
    localparam int unsigned IW     = DEPTH_LOG2;
    localparam int unsigned NWORDS = 1 << DEPTH_LOG2;
    localparam int unsigned NBYTES = DW / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [DW-1:0] mem_q [NWORDS];

    // Write path state
    w_state_e      w_state_q, w_state_d;
    logic          awready_q, awready_d;
    logic          wready_q,  wready_d;
    logic          bvalid_q,  bvalid_d;
    logic [1:0]    bresp_q,   bresp_d;
    logic [IW-1:0] w_idx_q,   w_idx_d;
    logic [7:0]    w_cnt_q,   w_cnt_d;
    logic          w_fixed_q, w_fixed_d;
    logic          w_aerr_q,  w_aerr_d;
    logic          w_err_q,   w_err_d;
    logic          w_beat_c;
    logic          aw_err_c;
    logic          w_last_bad_c;

    // Read path state
    r_state_e      r_state_q, r_state_d;
    logic          arready_q, arready_d;
    logic          rvalid_q,  rvalid_d;
    logic          rlast_q,   rlast_d;
    logic [1:0]    rresp_q,   rresp_d;
    logic [DW-1:0] rdata_q,   rdata_d;
    logic [IW-1:0] r_idx_q,   r_idx_d;
    logic [7:0]    r_cnt_q,   r_cnt_d;
    logic          r_fixed_q, r_fixed_d;
    logic          r_err_q,   r_err_d;
    logic [IW-1:0] ar_idx_c;
    logic [IW-1:0] r_next_idx_c;
    logic          ar_err_c;

    // Address bits outside the word index are ignored by design
    logic unused_addr_c;
    assign unused_addr_c = ^{axi.axi_awaddr, axi.axi_araddr};

    assign aw_err_c     = (axi.axi_awsize != 3'd3) || axi.axi_awburst[1];
    assign ar_err_c     = (axi.axi_arsize != 3'd3) || axi.axi_arburst[1];
    assign w_last_bad_c = axi.axi_wlast != (w_cnt_q == 8'd0);
    assign ar_idx_c     = axi.axi_araddr[IW+2:3];
    assign r_next_idx_c = r_fixed_q ? r_idx_q : r_idx_q + IW'(1);

    // Write FSM next-state and registered-output logic
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        w_fixed_d = w_fixed_q;
        w_aerr_d  = w_aerr_q;
        w_err_d   = w_err_q;
        w_beat_c  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (axi.axi_awvalid && awready_q) begin
                    w_idx_d   = axi.axi_awaddr[IW+2:3];
                    w_cnt_d   = axi.axi_awlen;
                    w_fixed_d = (axi.axi_awburst == 2'b00);
                    w_aerr_d  = aw_err_c;
                    w_err_d   = aw_err_c;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi.axi_wvalid && wready_q) begin
                    w_beat_c = 1'b1;
                    w_err_d  = w_err_q | w_last_bad_c;
                    if (w_cnt_q == 8'd0) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q | w_last_bad_c) ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q - 8'd1;
                        if (!w_fixed_q) begin
                            w_idx_d = w_idx_q + IW'(1);
                        end
                    end
                end
            end
            W_RESP: begin
                if (axi.axi_bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Write FSM state register
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            w_idx_q   <= '0;
            w_cnt_q   <= 8'd0;
            w_fixed_q <= 1'b0;
            w_aerr_q  <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_fixed_q <= w_fixed_d;
            w_aerr_q  <= w_aerr_d;
            w_err_q   <= w_err_d;
        end
    end

    // Byte-strobed memory write; address-phase error bursts never touch memory
    always_ff @(posedge axi_aclk) begin
        if (w_beat_c && !w_aerr_q) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (axi.axi_wstrb[b]) begin
                    mem_q[w_idx_q][b*8 +: 8] <= axi.axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM next-state and registered-output logic; memory read sees pre-write contents
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        r_fixed_d = r_fixed_q;
        r_err_d   = r_err_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi.axi_arvalid && arready_q) begin
                    r_idx_d   = ar_idx_c;
                    r_cnt_d   = axi.axi_arlen;
                    r_fixed_d = (axi.axi_arburst == 2'b00);
                    r_err_d   = ar_err_c;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (axi.axi_arlen == 8'd0);
                    rresp_d   = ar_err_c ? 2'b10 : 2'b00;
                    rdata_d   = ar_err_c ? '0 : mem_q[ar_idx_c];
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.axi_rready && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_next_idx_c;
                        r_cnt_d = r_cnt_q - 8'd1;
                        rlast_d = (r_cnt_q == 8'd1);
                        rdata_d = r_err_q ? '0 : mem_q[r_next_idx_c];
                    end
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Read FSM state register
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            r_idx_q   <= '0;
            r_cnt_q   <= 8'd0;
            r_fixed_q <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_fixed_q <= r_fixed_d;
            r_err_q   <= r_err_d;
        end
    end

    assign axi.axi_awready = awready_q;
    assign axi.axi_wready  = wready_q;
    assign axi.axi_bvalid  = bvalid_q;
    assign axi.axi_bresp   = bresp_q;
    assign axi.axi_arready = arready_q;
    assign axi.axi_rvalid  = rvalid_q;
    assign axi.axi_rlast   = rlast_q;
    assign axi.axi_rresp   = rresp_q;
    assign axi.axi_rdata   = rdata_q;
endmodule
